// File: rtl/sbox_share_compress.sv
// Two-stage compression of a 9-share expanded S-box output into 3 output shares.
// Stage A captures the raw share products; stage B holds the XOR-compressed result.
module sbox_share_compress #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [35:0]      in_q,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       out_y1,
   output logic [3:0]       out_y2,
   output logic [3:0]       out_y3,
   output logic             busy,
   output logic [CNT_W-1:0] out_count
);

   logic             a_valid_q, a_valid_d;
   logic             b_valid_q, b_valid_d;
   logic [35:0]      a_data_q, a_data_d;
   logic [2:0][3:0]  b_data_q, b_data_d;
   logic [2:0][3:0]  comp;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             in_hs, b_load, out_hs;

   assign in_ready = !a_valid_q || !b_valid_q || out_ready;
   assign in_hs    = in_valid && in_ready;
   assign b_load   = a_valid_q && (!b_valid_q || out_ready);
   assign out_hs   = b_valid_q && out_ready;

   // Share s, bit k folds the three adjacent cross-products a[9k+3s +: 3].
   always_comb begin
      comp = '0;
      for (int s = 0; s < 3; s++) begin
         for (int k = 0; k < 4; k++) begin
            comp[s][k] = ^a_data_q[9*k + 3*s +: 3];
         end
      end
   end

   // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      a_valid_d = a_valid_q;
      b_valid_d = b_valid_q;
      a_data_d  = a_data_q;
      b_data_d  = b_data_q;
      cnt_d     = cnt_q;
      if (in_hs) begin
         a_valid_d = 1'b1;
         a_data_d  = in_q;
      end else if (b_load) begin
         a_valid_d = 1'b0;
      end
      if (b_load) begin
         b_valid_d = 1'b1;
         b_data_d  = comp;
      end else if (out_ready) begin
         b_valid_d = 1'b0;
      end
      if (out_hs) cnt_d = cnt_q + CNT_W'(1);
   end

   // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
   // NOTE: data registers are reset too, so no share material from a discarded vector survives.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_valid_q <= 1'b0;
         b_valid_q <= 1'b0;
         a_data_q  <= '0;
         b_data_q  <= '0;
         cnt_q     <= '0;
      end else begin
         a_valid_q <= a_valid_d;
         b_valid_q <= b_valid_d;
         a_data_q  <= a_data_d;
         b_data_q  <= b_data_d;
         cnt_q     <= cnt_d;
      end
   end

   assign out_valid = b_valid_q;
   assign out_y1    = b_data_q[0];
   assign out_y2    = b_data_q[1];
   assign out_y3    = b_data_q[2];
   assign busy      = a_valid_q || b_valid_q;
   assign out_count = cnt_q;

endmodule

// File: tb/tb_sbox_share_compress.sv
// Directed and randomized checks of sbox_share_compress against a cycle model,
// with a second CNT_W=4 instance sharing the stimulus to exercise counter wrap.
module tb_sbox_share_compress;

   logic        clk = 1'b0;
   logic        rst, in_valid, out_ready;
   logic [35:0] in_q;
   logic        in_ready, out_valid, busy;
   logic [3:0]  out_y1, out_y2, out_y3;
   logic [15:0] out_count;
   logic        r4_in_ready, r4_out_valid, r4_busy;
   logic [3:0]  r4_y1, r4_y2, r4_y3, r4_count;

   int errors = 0;
   int checks = 0;

   // reference model state
   logic        m_av, m_bv;
   logic [35:0] m_a, m_bsrc;
   logic [11:0] m_b;
   int          m_cnt, n_in, n_out;

   always #5 clk = ~clk;

   sbox_share_compress #(.CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_q(in_q),
      .out_valid(out_valid), .out_ready(out_ready), .out_y1(out_y1), .out_y2(out_y2),
      .out_y3(out_y3), .busy(busy), .out_count(out_count));

   sbox_share_compress #(.CNT_W(4)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r4_in_ready), .in_q(in_q),
      .out_valid(r4_out_valid), .out_ready(out_ready), .out_y1(r4_y1), .out_y2(r4_y2),
      .out_y3(r4_y3), .busy(r4_busy), .out_count(r4_count));

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // {y3,y2,y1}: share s bit k = XOR over j of in[9k+3(s-1)+(j-1)]
   function automatic logic [11:0] compress(input logic [35:0] v);
      logic [11:0] r = '0;
      for (int s = 1; s <= 3; s++)
         for (int k = 0; k < 4; k++)
            for (int j = 1; j <= 3; j++)
               r[4*(s-1)+k] ^= v[9*k + 3*(s-1) + (j-1)];
      return r;
   endfunction

   function automatic logic [3:0] xor9(input logic [35:0] v);
      logic [3:0] r;
      for (int k = 0; k < 4; k++) r[k] = ^v[9*k +: 9];
      return r;
   endfunction

   // Check current outputs against the model, then advance model and clock one edge.
   task automatic tick();
      logic exp_rdy, hs_in, bl, hs_out;
      #1;
      exp_rdy = !m_av || !m_bv || out_ready;
      check("in_ready", in_ready, exp_rdy);
      check("out_valid", out_valid, m_bv);
      check("out_y", {out_y3, out_y2, out_y1}, m_b);
      check("busy", busy, m_av || m_bv);
      check("out_count", out_count, m_cnt[15:0]);
      check("w4_state", {r4_in_ready, r4_out_valid, r4_busy, r4_y3, r4_y2, r4_y1},
            {exp_rdy, m_bv, m_av || m_bv, m_b});
      check("w4_count", r4_count, m_cnt[3:0]);
      if (m_bv) check("share_xor", out_y1 ^ out_y2 ^ out_y3, xor9(m_bsrc));
      if (rst) begin
         m_av = 1'b0; m_bv = 1'b0; m_a = '0; m_b = '0; m_bsrc = '0; m_cnt = 0;
      end else begin
         hs_in  = in_valid && exp_rdy;
         bl     = m_av && (!m_bv || out_ready);
         hs_out = m_bv && out_ready;
         if (hs_out) begin m_cnt++; n_out++; end
         if (bl) begin m_b = compress(m_a); m_bsrc = m_a; end
         m_bv = bl ? 1'b1 : (out_ready ? 1'b0 : m_bv);
         if (hs_in) begin m_a = in_q; n_in++; end
         m_av = hs_in ? 1'b1 : (bl ? 1'b0 : m_av);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b1; in_q = '1; out_ready = 1'b0;
      tick(); tick();
      rst = 1'b0; in_valid = 1'b0;
      n_in = 0; n_out = 0;
   endtask

   task automatic send_one(input string tag, input logic [35:0] v, input logic [11:0] exp_y);
      in_q = v; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      check({tag, "_valid"}, out_valid, 1'b1);
      check({tag, "_y"}, {out_y3, out_y2, out_y1}, exp_y);
      tick();
   endtask

   initial begin
      int base;
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_q = '0;
      m_av = 1'b0; m_bv = 1'b0; m_a = '0; m_b = '0; m_bsrc = '0;
      m_cnt = 0; n_in = 0; n_out = 0;
      @(posedge clk); #1;

      do_reset();
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_y", {out_y3, out_y2, out_y1}, 12'h000);
      check("rst_busy", busy, 1'b0);
      check("rst_count", out_count, 16'd0);
      check("rst_in_ready", in_ready, 1'b1);

      // first vector: latency two edges, count bumps on the third
      in_q = 36'h000000001; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      check("lat_valid", out_valid, 1'b1);
      check("lat_y", {out_y3, out_y2, out_y1}, 12'h001);
      tick();
      check("lat_count", out_count, 16'd1);
      check("lat_drained", out_valid, 1'b0);

      send_one("bit35", 36'h800000000, 12'h800);
      send_one("ones",  36'hFFFFFFFFF, 12'hFFF);
      send_one("pair",  36'h000000003, 12'h000);
      send_one("mix",   36'h000001038, 12'h030);
      check("dir_count", out_count, 16'd5);

      // stall with both stages full, then simultaneous in/out shift
      out_ready = 1'b0; in_valid = 1'b1; in_q = 36'h000000001;
      tick();
      in_q = 36'h800000000;
      tick();
      in_q = 36'h000001000;
      #1;
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_y", {out_valid, out_y3, out_y2, out_y1}, 13'h1001);
      tick(); tick();
      check("stall_hold", {out_valid, busy, out_y3, out_y2, out_y1}, 14'h3001);
      check("stall_count", out_count, 16'd5);
      out_ready = 1'b1;
      tick();
      check("shift_y2", {out_valid, out_y3, out_y2, out_y1}, 13'h1800);
      in_valid = 1'b0;
      tick();
      check("shift_y3", {out_valid, out_y3, out_y2, out_y1}, 13'h1020);
      tick();
      check("shift_drain", out_valid, 1'b0);
      check("shift_count", out_count, 16'd8);

      // reset with both stages full and an input offered during reset
      out_ready = 1'b0; in_valid = 1'b1; in_q = 36'h123456789;
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      check("midrst_valid", out_valid, 1'b0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_count", out_count, 16'd0);
      check("midrst_in_ready", in_ready, 1'b1);
      for (int i = 0; i < 4; i++) tick();
      check("midrst_quiet", {out_valid, out_count}, 17'd0);

      // 17 completions: narrow counter wraps to 1
      do_reset();
      out_ready = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 17; i++) begin
         in_q = 36'(i * 36'h0A5A5A5A5 + 3);
         tick();
      end
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      check("wrap_count16", out_count, 16'd17);
      check("wrap_count4", r4_count, 4'd1);

      // randomized traffic with stalls
      do_reset();
      base = 0;
      while (n_out < 1000 && base < 20000) begin
         in_valid  = (n_in < 1000) && ($urandom_range(3) != 0);
         out_ready = ($urandom_range(9) < 7);
         in_q      = {4'($urandom), $urandom};
         tick();
         base++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      check("rand_done", n_out, 1000);
      check("rand_count16", out_count, 16'd1000);
      check("rand_count4", r4_count, 4'd8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
